// File: rtl/redraw_scheduler.sv
// Redraw scheduler: snapshots the live display state, issues one draw_go per
// change burst, waits for draw_done with a stall timeout, then holds off MIN_GAP cycles.
module redraw_scheduler #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd800000,
  parameter logic [7:0]  MIN_GAP        = 8'd16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [53:0] cards,
  input  logic [8:0]  faceup,
  input  logic [1:0]  cursorID,
  input  logic [1:0]  menuDepth,
  input  logic [1:0]  winID,
  input  logic [3:0]  menuOFF,
  input  logic        force_redraw,
  input  logic        clear_err,
  input  logic        draw_done,
  output logic        draw_go,
  output logic [53:0] cards_q,
  output logic [8:0]  faceup_q,
  output logic [1:0]  cursorID_q,
  output logic [1:0]  menuDepth_q,
  output logic [1:0]  winID_q,
  output logic [3:0]  menuOFF_q,
  output logic        busy,
  output logic        timeout_err,
  output logic [7:0]  redraw_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GO   = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        dirty;
  logic        dirty_next;
  logic [19:0] timer;
  logic [19:0] timer_next;
  logic [7:0]  gap_cnt;
  logic [7:0]  gap_next;
  logic        load_snap;
  logic        err_set;
  logic        count_inc;
  logic        changed;
  logic        err_next;

  function automatic logic live_differs(
    input logic [53:0] c,  input logic [53:0] cq,
    input logic [8:0]  f,  input logic [8:0]  fq,
    input logic [1:0]  cu, input logic [1:0]  cuq,
    input logic [1:0]  md, input logic [1:0]  mdq,
    input logic [1:0]  w,  input logic [1:0]  wq,
    input logic [3:0]  mo, input logic [3:0]  moq
  );
    live_differs = (c != cq) || (f != fq) || (cu != cuq) ||
                   (md != mdq) || (w != wq) || (mo != moq);
  endfunction

  // Comparison against the held snapshot, so a change that reverts before sampling is invisible
  always_comb begin
    changed = live_differs(cards, cards_q, faceup, faceup_q, cursorID, cursorID_q,
                           menuDepth, menuDepth_q, winID, winID_q, menuOFF, menuOFF_q);
  end

  // Next-state logic for the scheduler FSM and its counters
  always_comb begin
    state_next = state;
    dirty_next = dirty | changed | force_redraw;
    timer_next = timer;
    gap_next   = gap_cnt;
    load_snap  = 1'b0;
    err_set    = 1'b0;
    count_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (dirty) begin
          state_next = S_GO;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_GO: begin
        load_snap  = 1'b1;
        dirty_next = force_redraw;
        timer_next = 20'd0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes priority over a coincident timeout
        if (draw_done) begin
          count_inc  = 1'b1;
          gap_next   = 8'd0;
          state_next = S_GAP;
        end else if (timer == (TIMEOUT_CYCLES - 20'd1)) begin
          err_set    = 1'b1;
          dirty_next = 1'b1;
          gap_next   = 8'd0;
          state_next = S_GAP;
        end else begin
          timer_next = timer + 20'd1;
          state_next = S_WAIT;
        end
      end
      S_GAP: begin
        if (gap_cnt == (MIN_GAP - 8'd1)) begin
          state_next = S_IDLE;
        end else begin
          gap_next   = gap_cnt + 8'd1;
          state_next = S_GAP;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Sticky error: a new stall wins over a simultaneous clear
  always_comb begin
    if (err_set) begin
      err_next = 1'b1;
    end else if (clear_err) begin
      err_next = 1'b0;
    end else begin
      err_next = timeout_err;
    end
  end

  // State, flags and counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      dirty        <= 1'b1;
      timer        <= 20'd0;
      gap_cnt      <= 8'd0;
      timeout_err  <= 1'b0;
      redraw_count <= 8'd0;
      draw_go      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      dirty        <= dirty_next;
      timer        <= timer_next;
      gap_cnt      <= gap_next;
      timeout_err  <= err_next;
      redraw_count <= count_inc ? (redraw_count + 8'd1) : redraw_count;
      draw_go      <= (state_next == S_GO);
      busy         <= (state_next == S_GO) || (state_next == S_WAIT);
    end
  end

  // Snapshot registers only move on the edge leaving S_GO
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cards_q     <= 54'd0;
      faceup_q    <= 9'd0;
      cursorID_q  <= 2'd0;
      menuDepth_q <= 2'd0;
      winID_q     <= 2'd0;
      menuOFF_q   <= 4'd0;
    end else if (load_snap) begin
      cards_q     <= cards;
      faceup_q    <= faceup;
      cursorID_q  <= cursorID;
      menuDepth_q <= menuDepth;
      winID_q     <= winID;
      menuOFF_q   <= menuOFF;
    end else begin
      cards_q     <= cards_q;
      faceup_q    <= faceup_q;
      cursorID_q  <= cursorID_q;
      menuDepth_q <= menuDepth_q;
      winID_q     <= winID_q;
      menuOFF_q   <= menuOFF_q;
    end
  end

endmodule

// File: tb/tb_redraw_scheduler.sv
// Directed testbench for redraw_scheduler with TIMEOUT_CYCLES=20, MIN_GAP=16.
module tb_redraw_scheduler;

  logic        clock;
  logic        reset;
  logic [53:0] cards;
  logic [8:0]  faceup;
  logic [1:0]  cursorID;
  logic [1:0]  menuDepth;
  logic [1:0]  winID;
  logic [3:0]  menuOFF;
  logic        force_redraw;
  logic        clear_err;
  logic        draw_done;
  logic        draw_go;
  logic [53:0] cards_q;
  logic [8:0]  faceup_q;
  logic [1:0]  cursorID_q;
  logic [1:0]  menuDepth_q;
  logic [1:0]  winID_q;
  logic [3:0]  menuOFF_q;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  redraw_count;

  int          checks;
  int          errors;
  logic [7:0]  exp_count;

  redraw_scheduler #(.TIMEOUT_CYCLES(20'd20), .MIN_GAP(8'd16)) dut (
    .clock(clock), .reset(reset), .cards(cards), .faceup(faceup),
    .cursorID(cursorID), .menuDepth(menuDepth), .winID(winID), .menuOFF(menuOFF),
    .force_redraw(force_redraw), .clear_err(clear_err), .draw_done(draw_done),
    .draw_go(draw_go), .cards_q(cards_q), .faceup_q(faceup_q), .cursorID_q(cursorID_q),
    .menuDepth_q(menuDepth_q), .winID_q(winID_q), .menuOFF_q(menuOFF_q),
    .busy(busy), .timeout_err(timeout_err), .redraw_count(redraw_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic run_cycles(input int n, output int gos);
    gos = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (draw_go === 1'b1) gos++;
    end
  endtask

  task automatic pulse_done();
    draw_done = 1'b1;
    @(negedge clock);
    draw_done = 1'b0;
  endtask

  task automatic wait_go(input string name);
    int n;
    n = 0;
    while (draw_go !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (draw_go !== 1'b1) begin
      errors++;
      $display("FAIL %s: draw_go got %b expected 1 within 100 cycles", name, draw_go);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    @(negedge clock);
    checks += 6;
    if (draw_go !== 1'b0) begin errors++; $display("FAIL rst_go: got %b expected 0", draw_go); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", timeout_err); end
    if (redraw_count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", redraw_count); end
    if (cards_q !== 54'd0) begin errors++; $display("FAIL rst_cards: got %0h expected 0", cards_q); end
    if (cursorID_q !== 2'd0) begin errors++; $display("FAIL rst_cursor: got %0d expected 0", cursorID_q); end
  endtask

  task automatic test_initial_draw();
    int gos;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (draw_go !== 1'b1) begin errors++; $display("FAIL init_go: got %b expected 1", draw_go); end
    run_cycles(5, gos);
    checks++;
    if (gos !== 0) begin errors++; $display("FAIL init_extra_go: got %0d expected 0", gos); end
    pulse_done();
    exp_count = exp_count + 8'd1;
    run_cycles(40, gos);
    checks += 3;
    if (gos !== 0) begin errors++; $display("FAIL init_quiet: got %0d gos expected 0", gos); end
    if (redraw_count !== exp_count) begin errors++; $display("FAIL init_count: got %0d expected %0d", redraw_count, exp_count); end
    if (busy !== 1'b0) begin errors++; $display("FAIL init_busy: got %b expected 0", busy); end
  endtask

  task automatic test_latency();
    int gos;
    cursorID = 2'd2;
    @(negedge clock);
    checks++;
    if (draw_go !== 1'b0) begin errors++; $display("FAIL lat_early: got %b expected 0", draw_go); end
    @(negedge clock);
    checks += 2;
    if (draw_go !== 1'b1) begin errors++; $display("FAIL lat_go: got %b expected 1", draw_go); end
    if (cursorID_q !== 2'd0) begin errors++; $display("FAIL lat_snap_pre: got %0d expected 0", cursorID_q); end
    @(negedge clock);
    checks += 3;
    if (cursorID_q !== 2'd2) begin errors++; $display("FAIL lat_snap: got %0d expected 2", cursorID_q); end
    if (draw_go !== 1'b0) begin errors++; $display("FAIL lat_go_width: got %b expected 0", draw_go); end
    if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy: got %b expected 1", busy); end
    pulse_done();
    exp_count = exp_count + 8'd1;
    run_cycles(30, gos);
    checks += 2;
    if (gos !== 0) begin errors++; $display("FAIL lat_quiet: got %0d gos expected 0", gos); end
    if (redraw_count !== exp_count) begin errors++; $display("FAIL lat_count: got %0d expected %0d", redraw_count, exp_count); end
  endtask

  task automatic test_revert();
    int gos;
    cursorID = 2'd3;
    #2;
    cursorID = 2'd2;
    run_cycles(30, gos);
    checks++;
    if (gos !== 0) begin errors++; $display("FAIL revert: got %0d gos expected 0", gos); end
  endtask

  task automatic test_change_during_wait();
    int gos;
    cursorID = 2'd1;
    wait_go("wait_go1");
    @(negedge clock);
    faceup = 9'h001;
    @(negedge clock);
    faceup = 9'h0F0;
    @(negedge clock);
    faceup = 9'h1AA;
    @(negedge clock);
    checks += 2;
    if (faceup_q !== 9'h000) begin errors++; $display("FAIL wait_snap_hold: got %0h expected 0", faceup_q); end
    if (cursorID_q !== 2'd1) begin errors++; $display("FAIL wait_cursor: got %0d expected 1", cursorID_q); end
    pulse_done();
    exp_count = exp_count + 8'd1;
    run_cycles(16, gos);
    checks++;
    if (gos !== 0) begin errors++; $display("FAIL gap_go: got %0d gos expected 0", gos); end
    @(negedge clock);
    checks++;
    if (draw_go !== 1'b1) begin errors++; $display("FAIL followup_go: got %b expected 1", draw_go); end
    @(negedge clock);
    checks++;
    if (faceup_q !== 9'h1AA) begin errors++; $display("FAIL followup_snap: got %0h expected 1aa", faceup_q); end
    pulse_done();
    exp_count = exp_count + 8'd1;
    run_cycles(40, gos);
    checks++;
    if (gos !== 0) begin errors++; $display("FAIL followup_single: got %0d gos expected 0", gos); end
    pulse_done();
    @(negedge clock);
    checks++;
    if (redraw_count !== exp_count) begin errors++; $display("FAIL done_idle_ignored: got %0d expected %0d", redraw_count, exp_count); end
  endtask

  task automatic test_timeout();
    int gos;
    int viol;
    winID = 2'd3;
    wait_go("wait_go_to");
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (busy !== 1'b1 || timeout_err !== 1'b0) viol++;
    end
    clear_err = 1'b1;
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL to_wait_window: got %0d bad cycles expected 0", viol); end
    @(negedge clock);
    clear_err = 1'b0;
    checks += 3;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set: got %b expected 1", timeout_err); end
    if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b expected 0", busy); end
    if (redraw_count !== exp_count) begin errors++; $display("FAIL to_count: got %0d expected %0d", redraw_count, exp_count); end
    run_cycles(16, gos);
    checks++;
    if (gos !== 0) begin errors++; $display("FAIL to_gap: got %0d gos expected 0", gos); end
    @(negedge clock);
    checks += 2;
    if (draw_go !== 1'b1) begin errors++; $display("FAIL to_retry: got %b expected 1", draw_go); end
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
    @(negedge clock);
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", timeout_err); end
    pulse_done();
    exp_count = exp_count + 8'd1;
    run_cycles(30, gos);
    checks += 2;
    if (gos !== 0) begin errors++; $display("FAIL to_quiet: got %0d gos expected 0", gos); end
    if (redraw_count !== exp_count) begin errors++; $display("FAIL to_retry_count: got %0d expected %0d", redraw_count, exp_count); end
  endtask

  task automatic test_done_at_timeout();
    int gos;
    menuOFF = 4'hA;
    wait_go("wait_go_coin");
    repeat (20) @(negedge clock);
    pulse_done();
    exp_count = exp_count + 8'd1;
    checks += 3;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL coin_err: got %b expected 0", timeout_err); end
    if (redraw_count !== exp_count) begin errors++; $display("FAIL coin_count: got %0d expected %0d", redraw_count, exp_count); end
    if (busy !== 1'b0) begin errors++; $display("FAIL coin_busy: got %b expected 0", busy); end
    run_cycles(30, gos);
    checks++;
    if (gos !== 0) begin errors++; $display("FAIL coin_quiet: got %0d gos expected 0", gos); end
  endtask

  task automatic test_wrap_and_reset();
    cards = 54'h2A_5555_1234_ABCD;
    force_redraw = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wait_go("wait_go_wrap");
      @(negedge clock);
      pulse_done();
      exp_count = exp_count + 8'd1;
      if (exp_count == 8'd0) begin
        checks++;
        if (redraw_count !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", redraw_count); end
      end
    end
    force_redraw = 1'b0;
    checks++;
    if (redraw_count !== exp_count) begin errors++; $display("FAIL wrap_final: got %0d expected %0d", redraw_count, exp_count); end
    wait_go("wait_go_pre_rst");
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks += 6;
    if (draw_go !== 1'b0) begin errors++; $display("FAIL arst_go: got %b expected 0", draw_go); end
    if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
    if (redraw_count !== 8'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", redraw_count); end
    if (cards_q !== 54'd0) begin errors++; $display("FAIL arst_cards: got %0h expected 0", cards_q); end
    if (faceup_q !== 9'd0) begin errors++; $display("FAIL arst_faceup: got %0h expected 0", faceup_q); end
    if (menuOFF_q !== 4'd0) begin errors++; $display("FAIL arst_menuoff: got %0h expected 0", menuOFF_q); end
    @(negedge clock);
    reset = 1'b0;
    wait_go("wait_go_post_rst");
    @(negedge clock);
    checks++;
    if (cards_q !== 54'h2A_5555_1234_ABCD) begin errors++; $display("FAIL post_rst_snap: got %0h expected 2a55551234abcd", cards_q); end
    pulse_done();
    checks++;
    if (redraw_count !== 8'd1) begin errors++; $display("FAIL post_rst_count: got %0d expected 1", redraw_count); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    exp_count    = 8'd0;
    reset        = 1'b1;
    cards        = 54'd0;
    faceup       = 9'd0;
    cursorID     = 2'd0;
    menuDepth    = 2'd0;
    winID        = 2'd0;
    menuOFF      = 4'd0;
    force_redraw = 1'b0;
    clear_err    = 1'b0;
    draw_done    = 1'b0;
    test_reset();
    test_initial_draw();
    test_latency();
    test_revert();
    test_change_during_wait();
    test_timeout();
    test_done_at_timeout();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/redraw_scheduler.md
REDRAW_SCHEDULER -- requirements
Module: redraw_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 20'd800000, maximum cycles to wait for draw_done before declaring a stalled draw (SHALL be >=2).
REQ-002 Parameter MIN_GAP, 8'd16, idle hold-off cycles between consecutive draws (SHALL be >=1).
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces every register to its reset value immediately.
REQ-005 cards  input  54  live card codes (9 x 6-bit).
REQ-006 faceup  input  9  live face-up mask.
REQ-007 cursorID  input  2  live cursor slot.
REQ-008 menuDepth  input  2  live menu level.
REQ-009 winID  input  2  live winner id.
REQ-010 menuOFF  input  4  live menu-disable mask.
REQ-011 force_redraw  input  1  single-cycle request to redraw regardless of change.
REQ-012 clear_err  input  1  clears timeout_err.
REQ-013 draw_done  input  1  one-cycle completion pulse from the screen-drawing FSM.
REQ-014 draw_go  output  1  one-cycle start pulse to the screen-drawing FSM.
REQ-015 cards_q, faceup_q, cursorID_q, menuDepth_q, winID_q, menuOFF_q  output  54/9/2/2/2/4  snapshot registers driving the drawer; constant while a draw is in progress.
REQ-016 busy  output  1  high in S_GO and S_WAIT.
REQ-017 timeout_err  output  1  sticky stalled-draw flag.
REQ-018 redraw_count  output  8  count of completed draws, wraps 255->0.

Function
REQ-019 Block SHALL keep a sticky dirty flag, set at a clock edge when any live input differs from its snapshot or force_redraw=1.
REQ-020 States SHALL be S_IDLE, S_GO, S_WAIT, S_GAP, registered, with only the transitions below.
REQ-021 S_IDLE: dirty=1 -> S_GO next edge; else stay.
REQ-022 S_GO (exactly one cycle): draw_go=1; at the exiting edge all snapshots load the live inputs, dirty loads force_redraw, wait timer clears; -> S_WAIT.
REQ-023 Latency: an input change sampled at edge k in S_IDLE SHALL give draw_go=1 in the cycle after edge k+1.
REQ-024 S_WAIT: timer increments each cycle; draw_done=1 -> S_GAP, redraw_count+1; timer reaching TIMEOUT_CYCLES-1 without draw_done -> S_GAP, timeout_err=1, dirty=1 (retry).
REQ-025 draw_done and timeout on the same edge SHALL be treated as completion (no error).
REQ-026 Input changes during S_GO/S_WAIT/S_GAP SHALL NOT alter snapshots; they set dirty by comparison against the held snapshot and produce one follow-up draw.
REQ-027 Multiple changes before S_GO SHALL coalesce into a single draw.
REQ-028 S_GAP: gap counter counts MIN_GAP cycles then -> S_IDLE; draw_go SHALL NOT assert in S_GAP.
REQ-029 draw_done outside S_WAIT SHALL be ignored.
REQ-030 clear_err=1 clears timeout_err next edge; simultaneous set and clear SHALL leave timeout_err=1.
REQ-031 An input change reverting to the snapshot value before being sampled SHALL NOT set dirty.

Reset
REQ-032 On reset: state S_IDLE, dirty=1 (forces one initial draw), all snapshots 0, draw_go=0, busy=0, timeout_err=0, redraw_count=0, timers 0.
REQ-033 Reset asserted mid-S_WAIT SHALL abandon the draw with no count increment; after release a fresh draw is issued.

Verification
REQ-034 Release reset, inputs static, draw_done 5 cycles after draw_go -> exactly one draw_go, redraw_count=1, then quiet with busy=0.
REQ-035 In S_IDLE set cursorID 0->2 at edge k -> draw_go in the cycle after edge k+1, cursorID_q=2 from the exiting edge of S_GO.
REQ-036 Change faceup 3 times during S_WAIT -> snapshots unchanged until done; exactly one further draw_go after MIN_GAP=16 gap cycles.
REQ-037 Withhold draw_done with TIMEOUT_CYCLES=20 -> timeout_err=1 after 20 S_WAIT cycles, retry draw_go after gap; clear_err -> timeout_err=0.
REQ-038 draw_done coincident with timeout edge -> timeout_err stays 0, redraw_count increments.
REQ-039 Force 256 completed draws via force_redraw -> redraw_count wraps to 0; reset asserted mid-S_WAIT -> all outputs at reset values asynchronously.
